// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_stage and fetch_pc_gen.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with sequential +4 advance and redirect load.
// Redirect takes priority over advance.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC =
    ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4
);

  logic [ADDRESS_WIDTH-1:0] pc_q;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= redirect_pc;
    end else if (advance) begin
      pc_q <= pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: drives imem req/ack handshake, buffers one instruction
// for the decode register, handles stalls and redirects.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC =
    ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc_i,
  output logic                     imem_req_o,
  output logic [ADDRESS_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0]    imem_rdata_i,
  input  logic                     imem_ack_i,
  output logic [DATA_WIDTH-1:0]    instrF_o,
  output logic [ADDRESS_WIDTH-1:0] pcF_o,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4F_o,
  output logic                     validF_o
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(NOP_INSTR);

  fetch_state_t             state_q;
  logic                     pending_q;
  logic [ADDRESS_WIDTH-1:0] req_addr_q;

  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    instr_q;
  logic [ADDRESS_WIDTH-1:0] pcf_q;
  logic [ADDRESS_WIDTH-1:0] pc4f_q;

  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] pc_plus4;

  logic req;
  logic done;
  logic accept;
  logic outstanding;
  logic hold_free;
  logic drain_done;

  fetch_pc_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .RESET_PC     (RESET_PC)
  ) u_pc_gen (
    .clk        (clk_i),
    .rst        (rst_i),
    .advance    (accept),
    .redirect   (redirect_i),
    .redirect_pc(redirect_pc_i),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  assign req = !rst_i & (pending_q
             | (state_q == FETCH)
             | ((state_q == HOLD) & !stall_i));

  assign imem_req_o  = req;
  assign imem_addr_o = pending_q ? req_addr_q : pc;

  assign done        = req & imem_ack_i;
  assign outstanding = req & !imem_ack_i;
  assign accept      = done & !redirect_i & (state_q != DRAIN);
  assign hold_free   = (state_q == HOLD) & !stall_i;
  assign drain_done  = (state_q == DRAIN) & done;

  // pc_q never moves while a request is pending outside DRAIN,
  // so the buffered PC always matches the returned data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      pending_q  <= 1'b0;
      req_addr_q <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP;
      pcf_q      <= RESET_PC;
      pc4f_q     <= RESET_PC + ADDRESS_WIDTH'(4);
    end else begin
      if (outstanding) begin
        pending_q  <= 1'b1;
        req_addr_q <= imem_addr_o;
      end else if (done) begin
        pending_q  <= 1'b0;
      end

      priority case (1'b1)
        redirect_i: begin
          state_q <= outstanding ? DRAIN : FETCH;
          valid_q <= 1'b0;
          instr_q <= NOP;
        end
        accept: begin
          state_q <= HOLD;
          valid_q <= 1'b1;
          instr_q <= imem_rdata_i;
          pcf_q   <= pc;
          pc4f_q  <= pc_plus4;
        end
        hold_free: begin
          state_q <= FETCH;
          valid_q <= 1'b0;
          instr_q <= NOP;
        end
        drain_done: begin
          state_q <= FETCH;
        end
        default: begin
        end
      endcase
    end
  end

  assign validF_o    = valid_q;
  assign instrF_o    = instr_q;
  assign pcF_o       = pcf_q;
  assign pc_plus4F_o = pc4f_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable
// instruction memory model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        imem_ack_i;
  logic [31:0] instrF_o;
  logic [31:0] pcF_o;
  logic [31:0] pc_plus4F_o;
  logic        validF_o;

  int total = 0;
  int bad = 0;
  int lat = 0;
  int waitc;

  fetch_stage dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .imem_ack_i   (imem_ack_i),
    .instrF_o     (instrF_o),
    .pcF_o        (pcF_o),
    .pc_plus4F_o  (pc_plus4F_o),
    .validF_o     (validF_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h0) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0013);
  endfunction

  assign imem_ack_i   = imem_req_o && (waitc >= lat);
  assign imem_rdata_i = mem_fn(imem_addr_o);

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) waitc <= 0;
    else if (!imem_req_o || imem_ack_i) waitc <= 0;
    else waitc <= waitc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset(input int l);
    @(negedge clk_i);
    rst_i = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    lat = l;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=%0t exp=finish", $time);
    $fatal(1);
  end

  initial begin
    @(negedge clk_i);
    check("rst_valid", 32'(validF_o), 32'd0);
    check("rst_instr", instrF_o, NOP);
    check("rst_pc", pcF_o, 32'h0);
    check("rst_pc4", pc_plus4F_o, 32'h4);
    check("rst_req", 32'(imem_req_o), 32'd0);

    // zero-latency streaming
    do_reset(0);
    check("t1_req0", 32'(imem_req_o), 32'd1);
    check("t1_addr0", imem_addr_o, 32'h0);
    check("t1_valid0", 32'(validF_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_valid", 32'(validF_o), 32'd1);
      check("t1_pc", pcF_o, 32'(4 * i));
      check("t1_pc4", pc_plus4F_o, 32'(4 * i + 4));
      check("t1_instr", instrF_o, mem_fn(32'(4 * i)));
    end

    // memory acks after 3 wait cycles
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check("t2_addr_wait", imem_addr_o, 32'h0);
      check("t2_valid_wait", 32'(validF_o), 32'd0);
    end
    check("t2_ack", 32'(imem_ack_i), 32'd1);
    tick();
    check("t2_valid", 32'(validF_o), 32'd1);
    check("t2_instr", instrF_o, 32'hDEAD_BEEF);
    check("t2_pc", pcF_o, 32'h0);
    check("t2_next_addr", imem_addr_o, 32'h4);

    // stall while holding pc 0x8
    do_reset(0);
    repeat (3) tick();
    check("t3_pc8", pcF_o, 32'h8);
    stall_i = 1'b1;
    #1;
    check("t3_req_stall", 32'(imem_req_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_frozen_pc", pcF_o, 32'h8);
      check("t3_frozen_valid", 32'(validF_o), 32'd1);
      check("t3_frozen_req", 32'(imem_req_o), 32'd0);
    end
    stall_i = 1'b0;
    #1;
    check("t3_rel_req", 32'(imem_req_o), 32'd1);
    check("t3_rel_addr", imem_addr_o, 32'hC);
    tick();
    check("t3_next_pc", pcF_o, 32'hC);
    check("t3_next_valid", 32'(validF_o), 32'd1);

    // redirect while 0x10 is unacked -> drain
    do_reset(0);
    repeat (4) tick();
    check("t4_pcC", pcF_o, 32'hC);
    lat = 2;
    #1;
    check("t4_addr10", imem_addr_o, 32'h10);
    tick();
    check("t4_valid_wait", 32'(validF_o), 32'd0);
    check("t4_addr_pend", imem_addr_o, 32'h10);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    #1;
    check("t4_drain_addr", imem_addr_o, 32'h10);
    check("t4_drain_ack", 32'(imem_ack_i), 32'd1);
    check("t4_drain_instr", instrF_o, NOP);
    tick();
    check("t4_new_addr", imem_addr_o, 32'h100);
    check("t4_stale_valid", 32'(validF_o), 32'd0);
    check("t4_stale_instr", instrF_o, NOP);
    tick();
    check("t4_wait_valid", 32'(validF_o), 32'd0);
    tick();
    check("t4_ack100", 32'(imem_ack_i), 32'd1);
    tick();
    check("t4_valid", 32'(validF_o), 32'd1);
    check("t4_pc", pcF_o, 32'h100);
    check("t4_instr", instrF_o, mem_fn(32'h100));

    // redirect + stall + ack in the same cycle
    do_reset(1);
    tick();
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    #1;
    check("t5_ack_same", 32'(imem_ack_i), 32'd1);
    tick();
    stall_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    check("t5_valid_drop", 32'(validF_o), 32'd0);
    check("t5_instr_drop", instrF_o, NOP);
    check("t5_pc_hold", pcF_o, 32'h0);
    check("t5_addr40", imem_addr_o, 32'h40);
    check("t5_req", 32'(imem_req_o), 32'd1);
    tick();
    check("t5_wait_valid", 32'(validF_o), 32'd0);
    tick();
    check("t5_valid", 32'(validF_o), 32'd1);
    check("t5_pc", pcF_o, 32'h40);
    check("t5_instr", instrF_o, mem_fn(32'h40));

    // wrap at top of address space, then reset mid-wait
    do_reset(0);
    tick();
    check("t6_pc0", pcF_o, 32'h0);
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    #1;
    check("t6_valid_bub", 32'(validF_o), 32'd0);
    check("t6_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check("t6_pc_top", pcF_o, 32'hFFFF_FFFC);
    check("t6_pc4_wrap", pc_plus4F_o, 32'h0);
    check("t6_valid", 32'(validF_o), 32'd1);
    check("t6_addr_wrap", imem_addr_o, 32'h0);
    lat = 3;
    tick();
    check("t6_wait_valid", 32'(validF_o), 32'd0);
    check("t6_wait_addr", imem_addr_o, 32'h0);
    check("t6_pc_keep", pcF_o, 32'hFFFF_FFFC);
    rst_i = 1'b1;
    #1;
    check("t6_rst_valid", 32'(validF_o), 32'd0);
    check("t6_rst_instr", instrF_o, NOP);
    check("t6_rst_pc", pcF_o, 32'h0);
    check("t6_rst_pc4", pc_plus4F_o, 32'h4);
    check("t6_rst_req", 32'(imem_req_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
